// File: rtl/mips_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states and stream packing constants.
package mips_loader_pkg;
    typedef enum logic [1:0] {LEN_HI, LEN_LO, DATA, RUN} loader_state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);
endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port for single-cycle fetch.
module imem_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction RAM and holds the core in reset until done.
//   state  | meaning
//   LEN_HI | waiting for word-count high byte
//   LEN_LO | waiting for word-count low byte
//   DATA   | packing data bytes into words and writing RAM
//   RUN    | load complete, core released, stream blocked
module imem_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [7:0]      in_data,
    output logic            in_ready,
    input  logic            reload_req,
    input  logic [7:0]      pc_mini,
    output logic [31:0]     instr,
    output logic            cpu_reset,
    output logic            loading,
    output logic            err_ovf,
    output logic [ADDR_W:0] words_loaded
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    loader_state_t     state;
    logic [15:0]       len;
    logic [23:0]       shift_buf;
    logic [1:0]        byte_cnt;
    logic [15:0]       words_received;
    logic [ADDR_W-1:0] waddr;

    logic        accept;
    logic        word_done;
    logic        we;
    logic [31:0] wdata;

    assign in_ready  = (state != RUN);
    assign accept    = in_valid & in_ready;
    assign word_done = accept && (state == DATA) && (byte_cnt == LAST_BYTE);
    // Words past the RAM depth are still counted so the stream stays framed.
    assign we        = word_done && (words_received < DEPTH16);
    assign wdata     = {shift_buf, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= LEN_HI;
            len            <= '0;
            shift_buf      <= '0;
            byte_cnt       <= '0;
            words_received <= '0;
            waddr          <= '0;
            words_loaded   <= '0;
            err_ovf        <= 1'b0;
            cpu_reset      <= 1'b1;
            loading        <= 1'b1;
        end else begin
            cpu_reset <= (state != RUN) || reload_req;
            loading   <= (state != RUN) || reload_req;
            case (state)
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= in_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= in_data;
                        state    <= ({len[15:8], in_data} == 16'd0) ? RUN : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt       <= '0;
                            words_received <= words_received + 16'd1;
                            if (we) begin
                                waddr        <= waddr + 1'b1;
                                words_loaded <= words_loaded + 1'b1;
                            end else begin
                                err_ovf <= 1'b1;
                            end
                            if (words_received + 16'd1 == len) begin
                                state <= RUN;
                            end
                        end else begin
                            shift_buf <= {shift_buf[15:0], in_data};
                            byte_cnt  <= byte_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload_req) begin
                        state          <= LEN_HI;
                        len            <= '0;
                        byte_cnt       <= '0;
                        words_received <= '0;
                        waddr          <= '0;
                        words_loaded   <= '0;
                        err_ovf        <= 1'b0;
                    end
                end
                default: state <= LEN_HI;
            endcase
        end
    end

    imem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (pc_mini[ADDR_W+1:2]),
        .rdata (instr)
    );
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a word-array model of the RAM and load status.
module tb_imem_loader;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        reload_req;
    logic [7:0]  pc_mini;
    logic [31:0] instr;
    logic        cpu_reset;
    logic        loading;
    logic        err_ovf;
    logic [6:0]  words_loaded;

    int vectors;
    int miscompares;

    logic [31:0] model_mem [64];
    bit          known [64];
    logic [31:0] prog [$];

    imem_loader #(.ADDR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload_req   (reload_req),
        .pc_mini      (pc_mini),
        .instr        (instr),
        .cpu_reset    (cpu_reset),
        .loading      (loading),
        .err_ovf      (err_ovf),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // gap: 0 = back-to-back, 1 = one idle cycle before each byte, 2 = random idle with stray reload pulses
    task automatic send_byte(input logic [7:0] b, input int gap);
        int idle;
        idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 3)) : 0;
        for (int k = 0; k < idle; k++) begin
            in_valid   = 1'b0;
            in_data    = 8'($urandom);
            reload_req = (gap == 2) ? 1'($urandom) : 1'b0;
            @(posedge clk); #1;
        end
        reload_req = 1'b0;
        chk("in_ready_load", {31'd0, in_ready}, 32'd1);
        chk("cpu_reset_load", {31'd0, cpu_reset}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (known[i]) begin
                pc_mini = {i[5:0], 2'($urandom)};
                #1;
                chk(tag, instr, model_mem[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic load(input int n, input int gap);
        logic [15:0] len;
        logic [31:0] w;
        int          exp_wl;
        len = 16'(n);
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8], gap);
            end
            if (i < 64) begin
                model_mem[i] = w;
                known[i]     = 1'b1;
            end
        end
        exp_wl = (n > 64) ? 64 : n;
        chk("in_ready_run", {31'd0, in_ready}, 32'd0);
        chk("cpu_reset_lag", {31'd0, cpu_reset}, 32'd1);
        @(posedge clk); #1;
        chk("cpu_reset_run", {31'd0, cpu_reset}, 32'd0);
        chk("loading_run", {31'd0, loading}, 32'd0);
        chk("words_loaded", {25'd0, words_loaded}, 32'(exp_wl));
        chk("err_ovf", {31'd0, err_ovf}, (n > 64) ? 32'd1 : 32'd0);
        check_mem("mem_after_load");
    endtask

    task automatic do_reload(input logic with_byte);
        reload_req = 1'b1;
        in_valid   = with_byte;
        in_data    = 8'hFF;
        @(posedge clk); #1;
        reload_req = 1'b0;
        in_valid   = 1'b0;
        chk("reload_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reload_loading", {31'd0, loading}, 32'd1);
        chk("reload_err_ovf", {31'd0, err_ovf}, 32'd0);
        chk("reload_words", {25'd0, words_loaded}, 32'd0);
    endtask

    task automatic rand_prog(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    initial begin
        logic [31:0] w0;
        logic [31:0] old1;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) known[i] = 1'b0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        reload_req = 1'b0;
        pc_mini    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_loading", {31'd0, loading}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
        chk("rst_words", {25'd0, words_loaded}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        prog = '{32'h20020005, 32'h2003000C};
        load(2, 0);

        do_reload(1'b0);
        load(2, 1);

        do_reload(1'b0);
        rand_prog(64);
        load(64, 2);

        do_reload(1'b0);
        load(0, 2);

        do_reload(1'b0);
        rand_prog(65);
        load(65, 0);

        // The 0xFF presented with the reload must not become the count's high byte.
        do_reload(1'b1);
        rand_prog(1);
        load(1, 2);

        do_reload(1'b0);
        rand_prog(2);
        w0   = prog[0];
        old1 = model_mem[1];
        send_byte(8'h00, 2);
        send_byte(8'h02, 2);
        for (int b = 0; b < 4; b++) send_byte(w0[31 - 8*b -: 8], 2);
        model_mem[0] = w0;
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("midrst_loading", {31'd0, loading}, 32'd1);
        chk("midrst_words", {25'd0, words_loaded}, 32'd0);
        pc_mini = 8'h04;
        #1;
        chk("midrst_old_mem1", instr, old1);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_hold_cpu", {31'd0, cpu_reset}, 32'd1);
        check_mem("mem_after_midrst");

        rand_prog(3);
        load(3, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
